ipsmacge_rxcfg: RTL and testbench
=================================

Name: ipsmacge_rxcfg

Overview:
Configuration sequencer for the 1-port triple-speed receive interface. Takes CPU requests for mode and speed, and optionally in-band RGMII link status. Changes to the interface controls (up_act, up_pos, up_gmii, up_mspd) are applied only at a frame boundary, after a guaranteed quiet period. It sits between the CPU register block and the receive interface, and monitors that interface's output (ogval/ogdat/ogdv/oger).

Parameters:
DRAIN_TO, 4096, max cycles to wait in DRAIN for frame end before forcing
HOLD_CYC, 4, cycles up_act held low before new mode applied (covers 2-stage input flops + output reg)
IBS_STBL, 8, consecutive identical in-band status samples required to accept a status
CNT_DW, 12, width of drain/hold counter (must hold DRAIN_TO)

Ports:
rxclk  in  1  receive clock; all logic on rising edge
rxrst_  in  1  asynchronous active-low reset
cfg_wr  in  1  one-cycle pulse: latch cfg_* as pending request
cfg_act  in  1  requested interface enable
cfg_pos  in  1  requested edge/lane select
cfg_gmii  in  1  requested 1=GMII/MII, 0=RGMII
cfg_mspd  in  2  requested speed: 00=10M, 01=100M, 10=1000M, 11=reserved
cfg_auto  in  1  1=speed follows in-band status (RGMII only); level, sampled live
ogval  in  1  receive interface byte valid
ogdat  in  8  receive interface byte
ogdv  in  1  receive interface data valid (frame in progress)
oger  in  1  receive interface error
up_act  out  1  applied enable
up_pos  out  1  applied edge select
up_gmii  out  1  applied interface type
up_mspd  out  2  applied speed
busy  out  1  sequence in progress (state != IDLE) or request pending
lnk_up  out  1  accepted in-band link status
lnk_dup  out  1  accepted in-band duplex (1=full)
ibs_spd  out  2  accepted in-band speed
chg_int  out  1  one-cycle pulse: accepted in-band status changed
drn_tmo  out  1  one-cycle pulse: DRAIN ended by timeout

Behaviour:
- Reset values: up_act=0, up_pos=0, up_gmii=0, up_mspd=00, busy=0, lnk_up=0, lnk_dup=0, ibs_spd=00, chg_int=0, drn_tmo=0. State=IDLE, pending cleared, counters 0.
- Pending register: one deep, holds {act,pos,gmii,mspd} plus a pend flag.
  - cfg_wr sets pend and overwrites the contents in any state; last write wins.
  - An auto request (below) loads the current applied values with mspd replaced, only if no cfg_wr occurs in the same cycle. CPU wins on collision.
- FSM states: IDLE, DRAIN, QUIET, APPLY, ENABLE.
- IDLE: if pend, clear pend, copy pending into the working config, go to DRAIN next cycle.
- DRAIN: counter increments each cycle.
  - If ogdv==0, go to QUIET and drive up_act=0 from the QUIET entry cycle.
  - Else, if the counter reaches DRAIN_TO-1, pulse drn_tmo and go to QUIET.
  - If up_act is already 0, ogdv is 0, so DRAIN lasts exactly 1 cycle.
- QUIET: up_act=0 for exactly HOLD_CYC cycles, then APPLY.
- APPLY: one cycle. up_pos/up_gmii/up_mspd load from the working config (visible the next cycle). A reserved mspd (11) is applied as-is; the interface gates it.
- ENABLE: one cycle. up_act <= working act. Go to IDLE. A pend set during the sequence starts a new sequence from IDLE.
- Latency: with no frame in progress, cfg_wr at cycle 0 gives new up_mspd at cycle 3+HOLD_CYC and up_act=1 at cycle 4+HOLD_CYC.
- busy = (state!=IDLE) | pend.
- In-band status (RGMII inter-frame):
  - A sample is valid when ogval & ~ogdv & ~oger & (ogdat[3:0]==ogdat[7:4]).
  - Fields: link=ogdat[0], spd=ogdat[2:1], dup=ogdat[3].
  - Valid sample equal to the candidate: stable counter increments, saturating at IBS_STBL. Differing sample: candidate loads, counter=1. Invalid samples leave both unchanged.
  - When the counter equals IBS_STBL and the candidate differs from the accepted {lnk_up,ibs_spd,lnk_dup}: accepted values update and chg_int pulses once.
  - A candidate with spd=11 is never accepted; its counter is held at 0.
  - Status decode runs regardless of up_gmii/cfg_auto.
- Auto request: issued in the cycle the accepted status changes, only if all hold: cfg_auto=1, up_gmii=0, working act=1, new lnk_up=1, new ibs_spd != up_mspd.
- Reset asserted mid-sequence: everything returns to reset values immediately; the pending request is lost.

Test Plan:
- Idle interface, cfg_wr {act=1,pos=1,gmii=0,mspd=10}, HOLD_CYC=4 -> up_mspd=10 at cycle 7, up_act=1 at cycle 8, busy low at cycle 9, drn_tmo never pulses.
- up_act=1, ogdv high for 200 cycles, cfg_wr mspd=01 at cycle 10 -> up_act stays 1 until ogdv falls (cycle 200), then 0 for 4 cycles, then up_mspd=01 and up_act=1.
- DRAIN_TO=64, ogdv stuck high, cfg_wr -> drn_tmo single pulse 64 cycles after DRAIN entry, then the sequence completes normally.
- Two cfg_wr (mspd=00, then mspd=01) during QUIET -> current sequence completes, one further sequence applies mspd=01; mspd=00 never reaches up_mspd.
- cfg_auto=1, RGMII, up_mspd=10, 8 inter-frame samples ogdat=0x33 (link=1, spd=01, dup=0) -> chg_int pulse, lnk_up=1, ibs_spd=01, auto sequence, up_mspd=01. Seven samples then 0x55 -> no change.
- Samples 0x77 (spd=11) x20 -> no chg_int, counter held 0. Assert rxrst_ in QUIET -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ipsmacge_rxcfg_if.sv
// Bundle between the CPU/receive side and the rx configuration sequencer.
// slave = sequencer side, master = CPU register block / interface monitor side.
interface ipsmacge_rxcfg_if;
  logic       cfg_wr;
  logic       cfg_act;
  logic       cfg_pos;
  logic       cfg_gmii;
  logic [1:0] cfg_mspd;
  logic       cfg_auto;
  logic       ogval;
  logic [7:0] ogdat;
  logic       ogdv;
  logic       oger;
  logic       up_act;
  logic       up_pos;
  logic       up_gmii;
  logic [1:0] up_mspd;
  logic       busy;
  logic       lnk_up;
  logic       lnk_dup;
  logic [1:0] ibs_spd;
  logic       chg_int;
  logic       drn_tmo;

  modport slave (
    input  cfg_wr, cfg_act, cfg_pos, cfg_gmii, cfg_mspd, cfg_auto,
    input  ogval, ogdat, ogdv, oger,
    output up_act, up_pos, up_gmii, up_mspd, busy,
    output lnk_up, lnk_dup, ibs_spd, chg_int, drn_tmo
  );

  modport master (
    output cfg_wr, cfg_act, cfg_pos, cfg_gmii, cfg_mspd, cfg_auto,
    output ogval, ogdat, ogdv, oger,
    input  up_act, up_pos, up_gmii, up_mspd, busy,
    input  lnk_up, lnk_dup, ibs_spd, chg_int, drn_tmo
  );
endinterface

// File: rtl/ipsmacge_rxcfg.sv
// Receive-interface configuration sequencer: applies mode/speed changes only at a frame
// boundary after a quiet period, and filters in-band RGMII link status.
module ipsmacge_rxcfg #(
  parameter int unsigned DRAIN_TO = 4096,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned IBS_STBL = 8,
  parameter int unsigned CNT_DW   = 12
) (
  input logic               rxclk,
  input logic               rxrst_,
  ipsmacge_rxcfg_if.slave   bus
);
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StQuiet  = 3'd2;
  localparam logic [2:0] StApply  = 3'd3;
  localparam logic [2:0] StEnable = 3'd4;
  localparam int unsigned SW = $clog2(IBS_STBL + 1);
  localparam logic [SW-1:0] StblMax = SW'(IBS_STBL);

  logic [2:0]        state_q, state_d;
  logic [CNT_DW-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [4:0]        pnd_q, pnd_d;    // {act, pos, gmii, mspd}
  logic [4:0]        wrk_q, wrk_d;
  logic              up_act_q, up_act_d;
  logic              up_pos_q, up_pos_d;
  logic              up_gmii_q, up_gmii_d;
  logic [1:0]        up_mspd_q, up_mspd_d;
  logic              drn_tmo_q, drn_tmo_d;
  logic [3:0]        cand_q, cand_d;  // {dup, spd, link}, same layout as ogdat[3:0]
  logic [SW-1:0]     stbl_q, stbl_d;
  logic [3:0]        acc_q;
  logic              chg_q;
  logic              take;

  logic       smp_vld;
  logic [3:0] smp;
  logic       accept;
  logic       auto_req;

  assign smp      = bus.ogdat[3:0];
  assign smp_vld  = bus.ogval & ~bus.ogdv & ~bus.oger & (bus.ogdat[3:0] == bus.ogdat[7:4]);
  // spd=11 candidates never reach StblMax, so they can never be accepted here.
  assign accept   = (stbl_q == StblMax) && (cand_q != acc_q);
  assign auto_req = accept & bus.cfg_auto & ~up_gmii_q & wrk_q[4] & cand_q[0] &
                    (cand_q[2:1] != up_mspd_q);

  always_comb begin
    cand_d = cand_q;
    stbl_d = stbl_q;
    if (smp_vld) begin
      if (smp[2:1] == 2'b11) begin
        cand_d = smp;
        stbl_d = '0;
      end else if (smp == cand_q) begin
        if (stbl_q != StblMax) stbl_d = stbl_q + 1'b1;
      end else begin
        cand_d = smp;
        stbl_d = SW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrk_d     = wrk_q;
    take      = 1'b0;
    up_act_d  = up_act_q;
    up_pos_d  = up_pos_q;
    up_gmii_d = up_gmii_q;
    up_mspd_d = up_mspd_q;
    drn_tmo_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          take    = 1'b1;
          wrk_d   = pnd_q;
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.ogdv || cnt_q == CNT_DW'(DRAIN_TO - 1)) begin
          drn_tmo_d = bus.ogdv;
          up_act_d  = 1'b0;
          cnt_d     = '0;
          state_d   = StQuiet;
        end
      end
      StQuiet: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_DW'(HOLD_CYC - 1)) begin
          {up_pos_d, up_gmii_d, up_mspd_d} = wrk_q[3:0];
          cnt_d   = '0;
          state_d = StApply;
        end
      end
      StApply: begin
        up_act_d = wrk_q[4];
        state_d  = StEnable;
      end
      StEnable: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // CPU write wins over an auto request issued in the same cycle.
  always_comb begin
    pend_d = pend_q;
    pnd_d  = pnd_q;
    if (bus.cfg_wr) begin
      pend_d = 1'b1;
      pnd_d  = {bus.cfg_act, bus.cfg_pos, bus.cfg_gmii, bus.cfg_mspd};
    end else if (auto_req) begin
      pend_d = 1'b1;
      pnd_d  = {up_act_q, up_pos_q, up_gmii_q, cand_q[2:1]};
    end else if (take) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge rxclk or negedge rxrst_) begin
    if (!rxrst_) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pnd_q     <= '0;
      wrk_q     <= '0;
      up_act_q  <= 1'b0;
      up_pos_q  <= 1'b0;
      up_gmii_q <= 1'b0;
      up_mspd_q <= 2'b00;
      drn_tmo_q <= 1'b0;
      cand_q    <= '0;
      stbl_q    <= '0;
      acc_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pnd_q     <= pnd_d;
      wrk_q     <= wrk_d;
      up_act_q  <= up_act_d;
      up_pos_q  <= up_pos_d;
      up_gmii_q <= up_gmii_d;
      up_mspd_q <= up_mspd_d;
      drn_tmo_q <= drn_tmo_d;
      cand_q    <= cand_d;
      stbl_q    <= stbl_d;
      chg_q     <= accept;
      if (accept) acc_q <= cand_q;
    end
  end

  assign bus.up_act  = up_act_q;
  assign bus.up_pos  = up_pos_q;
  assign bus.up_gmii = up_gmii_q;
  assign bus.up_mspd = up_mspd_q;
  assign bus.busy    = (state_q != StIdle) | pend_q;
  assign bus.lnk_up  = acc_q[0];
  assign bus.ibs_spd = acc_q[2:1];
  assign bus.lnk_dup = acc_q[3];
  assign bus.chg_int = chg_q;
  assign bus.drn_tmo = drn_tmo_q;
endmodule

// File: tb/tb_ipsmacge_rxcfg.sv
// Self-checking bench for ipsmacge_rxcfg: sequencer timing from closed-form event times,
// in-band status from a sliding window of the most recent valid samples.
module tb_ipsmacge_rxcfg;
  logic rxclk  = 1'b0;
  logic rxrst_ = 1'b0;

  ipsmacge_rxcfg_if bus ();

  ipsmacge_rxcfg #(
    .DRAIN_TO (64),
    .HOLD_CYC (4),
    .IBS_STBL (8),
    .CNT_DW   (12)
  ) dut (
    .rxclk  (rxclk),
    .rxrst_ (rxrst_),
    .bus    (bus)
  );

  always #5 rxclk = ~rxclk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Applied configuration as the bench believes it to be.
  logic       cur_act  = 1'b0;
  logic       cur_pos  = 1'b0;
  logic       cur_gmii = 1'b0;
  logic [1:0] cur_mspd = 2'b00;

  // Status model: accept when the last 8 valid samples agree, are not spd=11 and are new.
  logic [3:0] hist [8];
  int         hcnt = 0;
  logic [3:0] acc  = 4'h0;
  logic       exp_chg = 1'b0;

  initial forever begin
    @(negedge rxclk);
    if (!rxrst_) begin
      hcnt    = 0;
      acc     = 4'h0;
      exp_chg = 1'b0;
      check("ibs.rst_lnk_up", 32'(bus.lnk_up), 32'd0);
      check("ibs.rst_chg_int", 32'(bus.chg_int), 32'd0);
    end else begin
      logic same;
      check("ibs.lnk_up", 32'(bus.lnk_up), 32'(acc[0]));
      check("ibs.ibs_spd", 32'(bus.ibs_spd), 32'(acc[2:1]));
      check("ibs.lnk_dup", 32'(bus.lnk_dup), 32'(acc[3]));
      check("ibs.chg_int", 32'(bus.chg_int), 32'(exp_chg));
      same = (hcnt >= 8);
      for (int i = 1; i < 8; i++) if (hist[i] != hist[0]) same = 1'b0;
      exp_chg = 1'b0;
      if (same && hist[0][2:1] != 2'b11 && hist[0] != acc) begin
        acc     = hist[0];
        exp_chg = 1'b1;
      end
      if (bus.ogval && !bus.ogdv && !bus.oger && bus.ogdat[3:0] == bus.ogdat[7:4]) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.ogdat[3:0];
        if (hcnt < 8) hcnt++;
      end
    end
  end

  // One CPU request from idle; ogdv held high for the first l+2 cycles.
  task automatic run_seq(input logic a, input logic p, input logic g, input logic [1:0] m,
                         input int unsigned l);
    int unsigned q, ap, en;
    q  = 3 + ((l < 63) ? l : 63);
    ap = q + 4;
    en = ap + 1;
    for (int unsigned r = 0; r <= en + 2; r++) begin
      bus.cfg_wr   = (r == 0);
      bus.cfg_act  = a;
      bus.cfg_pos  = p;
      bus.cfg_gmii = g;
      bus.cfg_mspd = m;
      bus.ogdv     = (r < l + 2);
      @(negedge rxclk);
      check("seq.up_act", 32'(bus.up_act), 32'((r < q) ? cur_act : (r < en) ? 1'b0 : a));
      check("seq.up_pos", 32'(bus.up_pos), 32'((r < ap) ? cur_pos : p));
      check("seq.up_gmii", 32'(bus.up_gmii), 32'((r < ap) ? cur_gmii : g));
      check("seq.up_mspd", 32'(bus.up_mspd), 32'((r < ap) ? cur_mspd : m));
      check("seq.busy", 32'(bus.busy), 32'(r >= 1 && r <= en));
      check("seq.drn_tmo", 32'(bus.drn_tmo), 32'(r == q && l >= 64));
      @(posedge rxclk);
      #1;
    end
    bus.ogdv = 1'b0;
    cur_act  = a;
    cur_pos  = p;
    cur_gmii = g;
    cur_mspd = m;
  endtask

  logic [7:0] vals [8];
  logic [7:0] sval;
  int unsigned run;

  initial begin
    vals = '{8'h00, 8'h11, 8'h33, 8'h55, 8'h99, 8'hBB, 8'h77, 8'hDD};
    bus.cfg_wr = 1'b0; bus.cfg_act = 1'b0; bus.cfg_pos = 1'b0; bus.cfg_gmii = 1'b0;
    bus.cfg_mspd = 2'b00; bus.cfg_auto = 1'b0;
    bus.ogval = 1'b0; bus.ogdat = 8'h00; bus.ogdv = 1'b0; bus.oger = 1'b0;

    #2;
    check("rst.up_act", 32'(bus.up_act), 32'd0);
    check("rst.up_mspd", 32'(bus.up_mspd), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.drn_tmo", 32'(bus.drn_tmo), 32'd0);
    repeat (2) @(posedge rxclk);
    #1 rxrst_ = 1'b1;
    @(posedge rxclk);
    #1;

    // Idle interface, basic request
    run_seq(1'b1, 1'b1, 1'b0, 2'b10, 0);

    // Two writes while the first sequence is in QUIET; the middle one must never be applied
    for (int r = 0; r <= 18; r++) begin
      bus.cfg_wr   = (r == 0 || r == 4 || r == 5);
      bus.cfg_act  = 1'b1;
      bus.cfg_pos  = (r != 0);
      bus.cfg_gmii = (r == 0);
      bus.cfg_mspd = (r == 0) ? 2'b11 : (r == 4) ? 2'b00 : 2'b01;
      @(negedge rxclk);
      check("dbl.up_mspd", 32'(bus.up_mspd), 32'((r < 7) ? cur_mspd : (r < 15) ? 2'b11 : 2'b01));
      check("dbl.up_pos", 32'(bus.up_pos), 32'((r < 7) ? cur_pos : (r >= 15)));
      check("dbl.up_gmii", 32'(bus.up_gmii), 32'((r < 7) ? cur_gmii : (r < 15)));
      check("dbl.up_act", 32'(bus.up_act),
            32'((r < 3) ? cur_act : (r < 8) ? 1'b0 : (r < 11) ? 1'b1 : (r < 16) ? 1'b0 : 1'b1));
      check("dbl.busy", 32'(bus.busy), 32'(r >= 1 && r <= 16));
      @(posedge rxclk);
      #1;
    end
    bus.cfg_wr = 1'b0;
    cur_act = 1'b1; cur_pos = 1'b1; cur_gmii = 1'b0; cur_mspd = 2'b01;

    // Frame in progress, then drain timeout
    run_seq(1'b1, 1'b0, 1'b0, 2'b01, 30);
    run_seq(1'b1, 1'b1, 1'b1, 2'b00, 80);

    for (int k = 0; k < 10; k++)
      run_seq(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 90));

    // Auto speed from in-band status: RGMII, 1000M, then 8 samples of link=1/100M
    run_seq(1'b1, 1'b0, 1'b0, 2'b10, 0);
    bus.cfg_auto = 1'b1;
    for (int r = 0; r <= 20; r++) begin
      bus.ogval = (r < 8);
      bus.ogdat = 8'h33;
      @(negedge rxclk);
      check("auto.up_mspd", 32'(bus.up_mspd), 32'((r < 15) ? 2'b10 : 2'b01));
      check("auto.up_act", 32'(bus.up_act), 32'((r < 11) ? 1'b1 : (r < 16) ? 1'b0 : 1'b1));
      check("auto.busy", 32'(bus.busy), 32'(r >= 9 && r <= 16));
      check("auto.chg_int", 32'(bus.chg_int), 32'(r == 9));
      check("auto.lnk_up", 32'(bus.lnk_up), 32'(r >= 9));
      @(posedge rxclk);
      #1;
    end
    bus.ogval = 1'b0;
    bus.cfg_auto = 1'b0;
    cur_mspd = 2'b01;

    // Seven samples of a new status, then a different one; then 20 of spd=11
    for (int r = 0; r < 32; r++) begin
      bus.ogval = (r < 28);
      bus.ogdat = (r < 7) ? 8'h11 : (r == 7) ? 8'h55 : 8'h77;
      @(negedge rxclk);
      check("hold.chg_int", 32'(bus.chg_int), 32'd0);
      @(posedge rxclk);
      #1;
    end
    bus.ogval = 1'b0;
    check("hold.ibs_spd", 32'(bus.ibs_spd), 32'(2'b01));
    check("hold.lnk_up", 32'(bus.lnk_up), 32'd1);

    // Randomised in-band status traffic; the sequencer must stay idle
    run = 0;
    sval = 8'h00;
    for (int r = 0; r < 500; r++) begin
      if (run == 0) begin
        run  = $urandom_range(1, 12);
        sval = ($urandom_range(0, 9) == 0) ? 8'($urandom) : vals[$urandom_range(0, 7)];
      end
      run--;
      bus.ogval = ($urandom_range(0, 9) < 8);
      bus.ogdv  = ($urandom_range(0, 9) == 0);
      bus.oger  = ($urandom_range(0, 19) == 0);
      bus.ogdat = sval;
      @(negedge rxclk);
      check("stat.busy", 32'(bus.busy), 32'd0);
      @(posedge rxclk);
      #1;
    end
    bus.ogval = 1'b0; bus.ogdv = 1'b0; bus.oger = 1'b0;
    repeat (12) begin
      bus.ogval = 1'b1; bus.ogdat = 8'hDD;
      @(posedge rxclk);
      #1;
    end
    bus.ogval = 1'b0;
    check("stat.up_mspd", 32'(bus.up_mspd), 32'(cur_mspd));

    // Reset asserted while the sequencer is in QUIET
    for (int r = 0; r < 4; r++) begin
      bus.cfg_wr = (r == 0); bus.cfg_act = 1'b1; bus.cfg_pos = 1'b1;
      bus.cfg_gmii = 1'b1; bus.cfg_mspd = 2'b10;
      @(posedge rxclk);
      #1;
    end
    bus.cfg_wr = 1'b0;
    #2 rxrst_ = 1'b0;
    #1;
    check("qrst.up_act", 32'(bus.up_act), 32'd0);
    check("qrst.up_pos", 32'(bus.up_pos), 32'd0);
    check("qrst.up_gmii", 32'(bus.up_gmii), 32'd0);
    check("qrst.up_mspd", 32'(bus.up_mspd), 32'd0);
    check("qrst.busy", 32'(bus.busy), 32'd0);
    check("qrst.lnk_up", 32'(bus.lnk_up), 32'd0);
    check("qrst.lnk_dup", 32'(bus.lnk_dup), 32'd0);
    check("qrst.ibs_spd", 32'(bus.ibs_spd), 32'd0);
    check("qrst.chg_int", 32'(bus.chg_int), 32'd0);
    check("qrst.drn_tmo", 32'(bus.drn_tmo), 32'd0);
    repeat (2) @(posedge rxclk);
    #1 rxrst_ = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(negedge rxclk);
      check("qrst.busy_after", 32'(bus.busy), 32'd0);
      check("qrst.up_act_after", 32'(bus.up_act), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
